run_host: RTL
=============

Name: run_host

Overview:
Host-side initiator for the core's req/done run handshake.
- Holds the core in reset while it preloads data memory from an input stream.
- Pulses cpu_req to start the program, then counts cycles until cpu_done or a timeout.
- Streams a result window of data memory back out.
- Sits beside top_level in the bench/FPGA wrapper and owns the data memory write port while the core is not running.

Parameters:
AW, 8, data memory address width
DW, 8, data word width
LOAD_BASE, 0, first address written during preload
LOAD_LEN, 64, words accepted during preload (1..2**AW)
RES_BASE, 64, first address read back
RES_LEN, 64, words streamed out (1..2**AW)
TMO_W, 16, cycle counter width; timeout fires at count 2**TMO_W-1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
go  in  1  one-cycle start command; sampled only in IDLE
ld_valid  in  1  preload word valid
ld_data  in  DW  preload word
ld_ready  out  1  preload word accepted when ld_valid&ld_ready
cpu_reset  out  1  held high except in START/RUN
cpu_req  out  1  one-cycle start pulse to core
cpu_done  in  1  core finished; level
mem_wr_en  out  1  data memory write enable
mem_addr  out  AW  data memory address
mem_wdata  out  DW  data memory write data
mem_rdata  in  DW  data memory read data, combinational from mem_addr
mem_own  out  1  1 = host drives memory port, 0 = core drives it
rd_valid  out  1  result word valid
rd_data  out  DW  result word
rd_ready  in  1  result sink ready
busy  out  1  state != IDLE
timed_out  out  1  sticky; last run hit timeout
cycles  out  TMO_W  cycles from cpu_req to done/timeout; held until next go

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, cpu_reset=1, mem_own=1, cpu_req=0, ld_ready=0, mem_wr_en=0, rd_valid=0, busy=0, timed_out=0, cycles=0, index=0.
- States:
  - IDLE
    - go=1 -> LOAD; clear index, cycles, timed_out.
  - LOAD
    - ld_ready=1; mem_wr_en = ld_valid; mem_addr = LOAD_BASE+index (mod 2**AW); mem_wdata = ld_data.
    - Each handshake increments index.
    - Handshake with index=LOAD_LEN-1 -> START.
    - No backpressure on memory.
  - START
    - cpu_reset=0; cpu_req=1 for exactly this cycle; mem_own=0; cycles=0.
    - Next state is RUN.
  - RUN
    - cpu_reset=0; mem_own=0; cycles increments each cycle.
    - cpu_done=1 -> DRAIN, cycles frozen. Done on the first RUN cycle is legal and gives cycles=1.
    - cycles reaching 2**TMO_W-1 with no done -> timed_out=1 -> DRAIN. Done and timeout in the same cycle: done wins, timed_out=0.
  - DRAIN
    - cpu_reset=1; mem_own=1; index restarts at 0 on entry.
    - mem_addr = RES_BASE+index (wraps mod 2**AW); rd_data = mem_rdata; rd_valid=1.
    - Valid/data stay stable until rd_ready.
    - Handshake increments index. Handshake at index=RES_LEN-1 -> IDLE.
- go outside IDLE is ignored.
- reset in any state returns to IDLE within one cycle with reset values. A partial preload is abandoned; the memory contents are not cleared.
- mem_wr_en is never 1 outside LOAD.
- cpu_req is never high while cpu_reset=1.
- Address arithmetic is AW-bit modulo; index is AW+1 bits so LEN=2**AW is legal.

Decomposition:
- Package run_host_pkg:
  - enum state_t {IDLE, LOAD, START, RUN, DRAIN}
  - default widths and bases as localparams
- One sub-module is natural: run_host_ctr, a loadable up-counter with terminal-count flag. It is instantiated twice: index (AW+1 bits) and cycles (TMO_W bits).
- Address muxing and the FSM stay in run_host.

Test Plan:
- Reset mid-LOAD after 10 words -> next cycle state IDLE, ld_ready=0, cpu_reset=1, busy=0; a new go restarts at LOAD_BASE.
- LOAD_LEN=4, words 0x11,0x22,0x33,0x44 with ld_valid gapped every other cycle -> writes at addrs 0..3 only on handshake cycles; cpu_req pulses once, the cycle after the 4th handshake.
- Core model asserts cpu_done 37 cycles after cpu_req -> cycles=37, timed_out=0, rd_valid rises next cycle.
- TMO_W=4, cpu_done never -> timed_out=1, cycles=15; DRAIN still streams RES_LEN words.
- DRAIN with RES_BASE=254, RES_LEN=4, rd_ready toggling 1,0,0,1,... -> addresses 254,255,0,1; rd_data stable while stalled; IDLE after 4th handshake.
- go pulsed during RUN, and cpu_done coincident with the timeout terminal count -> go ignored; timed_out=0.

Source files
------------

// File: rtl/run_host_pkg.sv
// Shared types and default geometry for the run_host preload/run/drain initiator.
package run_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN
  } state_t;

  localparam int DEF_AW        = 8;
  localparam int DEF_DW        = 8;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 64;
  localparam int DEF_RES_BASE  = 64;
  localparam int DEF_RES_LEN   = 64;
  localparam int DEF_TMO_W     = 16;

endpackage

// File: rtl/run_host_ctr.sv
// Clearable up-counter with a compare-against-input terminal flag; count updates one cycle after inc.
// No backpressure: clr wins over inc, and the flag is combinational from the current count.
module run_host_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/run_host.sv
// Host initiator: preloads data memory with the core held in reset, starts it with cpu_req, times the run,
// then streams a result window out. Outputs are combinational from state; ld/rd streams follow valid/ready.
module run_host
  import run_host_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int RES_BASE  = DEF_RES_BASE,
  parameter int RES_LEN   = DEF_RES_LEN,
  parameter int TMO_W     = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             ld_valid,
  input  logic [DW-1:0]    ld_data,
  output logic             ld_ready,
  output logic             cpu_reset,
  output logic             cpu_req,
  input  logic             cpu_done,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             mem_own,
  output logic             rd_valid,
  output logic [DW-1:0]    rd_data,
  input  logic             rd_ready,
  output logic             busy,
  output logic             timed_out,
  output logic [TMO_W-1:0] cycles
);

  localparam int IW = AW + 1;
  // The run ends on the cycle whose increment lands on the all-ones count.
  localparam logic [TMO_W-1:0] CYC_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_tc_val;
  logic            idx_clr, idx_inc, idx_tc;
  logic            cyc_clr, cyc_inc, cyc_tc;
  logic            tmo_set, tmo_clr;

  run_host_ctr #(.W(IW)) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clr    (idx_clr),
    .inc    (idx_inc),
    .tc_val (idx_tc_val),
    .cnt    (idx),
    .tc     (idx_tc)
  );

  run_host_ctr #(.W(TMO_W)) u_cyc (
    .clk    (clk),
    .reset  (reset),
    .clr    (cyc_clr),
    .inc    (cyc_inc),
    .tc_val (CYC_LAST),
    .cnt    (cycles),
    .tc     (cyc_tc)
  );

  assign idx_tc_val = (state == DRAIN) ? IW'(RES_LEN - 1) : IW'(LOAD_LEN - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timed_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (tmo_clr) begin
        timed_out <= 1'b0;
      end else if (tmo_set) begin
        timed_out <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ld_ready  = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    cpu_req   = 1'b0;
    cpu_reset = 1'b1;
    mem_own   = 1'b1;
    rd_valid  = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    cyc_clr   = 1'b0;
    cyc_inc   = 1'b0;
    tmo_set   = 1'b0;
    tmo_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx = LOAD;
          idx_clr  = 1'b1;
          cyc_clr  = 1'b1;
          tmo_clr  = 1'b1;
        end
      end
      LOAD: begin
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        mem_addr  = AW'(LOAD_BASE) + idx[AW-1:0];
        if (ld_valid) begin
          idx_inc = 1'b1;
          if (idx_tc) begin
            state_nx = START;
          end
        end
      end
      START: begin
        cpu_reset = 1'b0;
        cpu_req   = 1'b1;
        mem_own   = 1'b0;
        cyc_clr   = 1'b1;
        idx_clr   = 1'b1;
        state_nx  = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        mem_own   = 1'b0;
        cyc_inc   = 1'b1;
        // Done takes priority over a coincident terminal count.
        if (cpu_done) begin
          state_nx = DRAIN;
        end else if (cyc_tc) begin
          tmo_set  = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        rd_valid = 1'b1;
        mem_addr = AW'(RES_BASE) + idx[AW-1:0];
        if (rd_ready) begin
          idx_inc = 1'b1;
          if (idx_tc) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_wdata = ld_data;
  assign rd_data   = mem_rdata;
  assign busy      = (state != IDLE);

endmodule
